// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared types and constants for the HD44780 LCD driver
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT_WAIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_EXEC      = 3'd5
    } lcd_state_t;

    localparam int IDX_RS  = 8;
    localparam int IDX_REQ = 9;
    localparam int IDX_ON  = 31;

    localparam logic [7:0] c_cmd_func_set = 8'h38;
    localparam logic [7:0] c_cmd_disp_on  = 8'h0C;
    localparam logic [7:0] c_cmd_clear    = 8'h01;
    localparam logic [7:0] c_cmd_entry    = 8'h06;
    localparam int         c_init_len     = 4;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = c_cmd_func_set;
            2'd1:    cmd = c_cmd_disp_on;
            2'd2:    cmd = c_cmd_clear;
            default: cmd = c_cmd_entry;
        endcase
        return cmd;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_driver.sv
// ============================================================================
// lcd_driver : HD44780 write-only bus sequencer with one-deep request buffer.
//              Optional power-up init sequence when LCD_INIT_EN is defined.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module lcd_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 25,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2500,
    parameter int T_EXEC_LONG = 82000,
    parameter int T_POWERUP   = 2000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam int c_max_t = max2(max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_EXEC)),
                                  max2(T_EXEC_LONG, T_POWERUP));
    localparam int c_cnt_w = $clog2(c_max_t + 1);

    localparam logic [c_cnt_w-1:0] c_setup_end = c_cnt_w'(T_SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_pulse_end = c_cnt_w'(T_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_hold_end  = c_cnt_w'(T_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_exec_end  = c_cnt_w'(T_EXEC - 1);
    localparam logic [c_cnt_w-1:0] c_long_end  = c_cnt_w'(T_EXEC_LONG - 1);
`ifdef LCD_INIT_EN
    localparam logic [c_cnt_w-1:0] c_powerup_end = c_cnt_w'(T_POWERUP - 1);
    localparam lcd_state_t         c_reset_state = ST_INIT_WAIT;
`else
    localparam lcd_state_t         c_reset_state = ST_IDLE;
`endif

    lcd_state_t          r_state;
    lcd_state_t          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_end;
    logic                w_last;

    logic                r_prev_req;
    logic                w_req;
    logic [7:0]          r_cap_data;
    logic                r_cap_rs;
    logic [7:0]          r_pend_data;
    logic                r_pend_rs;
    logic                r_pend_valid;
    logic                r_overrun;
    logic                r_busy;
    logic                r_en;
    logic                r_on;

    logic                w_init_left;
    logic [7:0]          w_init_byte;
    logic                w_init_step;
    logic                w_take_pend;
    logic                w_direct;
    logic                w_load;
    logic [7:0]          w_load_data;
    logic                w_load_rs;
    logic                w_queue;
    logic                w_fill;
    logic                w_drop;
    logic                w_pend_valid_nxt;
    logic                w_unused_word;

    assign w_req         = i_lcd_word[IDX_REQ] ^ r_prev_req;
    assign w_unused_word = ^i_lcd_word[30:10];

`ifdef LCD_INIT_EN
    logic [2:0] r_init_idx;

    assign w_init_left = (r_init_idx < 3'(c_init_len));
    assign w_init_byte = init_cmd(r_init_idx[1:0]);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_init_idx <= 3'd0;
        end else if (w_init_step) begin
            r_init_idx <= r_init_idx + 3'd1;
        end
    end
`else
    assign w_init_left = 1'b0;
    assign w_init_byte = 8'h00;
`endif

    // State register plus everything that advances with it
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= c_reset_state;
            r_cnt        <= '0;
            r_prev_req   <= 1'b0;
            r_cap_data   <= 8'h00;
            r_cap_rs     <= 1'b0;
            r_pend_data  <= 8'h00;
            r_pend_rs    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
            r_en         <= 1'b0;
            r_on         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= (w_last || r_state == ST_IDLE) ? '0 : r_cnt + 1'b1;
            r_prev_req   <= i_lcd_word[IDX_REQ];
            r_pend_valid <= w_pend_valid_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE) | w_pend_valid_nxt;
            r_en         <= (w_state_nxt == ST_PULSE);
            r_on         <= i_lcd_word[IDX_ON];
            if (w_load) begin
                r_cap_data <= w_load_data;
                r_cap_rs   <= w_load_rs;
            end
            if (w_fill) begin
                r_pend_data <= i_lcd_word[7:0];
                r_pend_rs   <= i_lcd_word[IDX_RS];
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Next-state logic, including phase length selection
    always_comb begin
        w_end = '0;
        case (r_state)
`ifdef LCD_INIT_EN
            ST_INIT_WAIT: w_end = c_powerup_end;
`endif
            ST_SETUP:     w_end = c_setup_end;
            ST_PULSE:     w_end = c_pulse_end;
            ST_HOLD:      w_end = c_hold_end;
            ST_EXEC:      w_end = is_long_cmd(r_cap_rs, r_cap_data) ? c_long_end : c_exec_end;
            default:      w_end = '0;
        endcase
        w_last = (r_state != ST_IDLE) && (r_cnt == w_end);

        w_state_nxt = r_state;
        case (r_state)
`ifdef LCD_INIT_EN
            ST_INIT_WAIT: if (w_last) w_state_nxt = ST_SETUP;
`endif
            ST_IDLE:      if (w_req)  w_state_nxt = ST_SETUP;
            ST_SETUP:     if (w_last) w_state_nxt = ST_PULSE;
            ST_PULSE:     if (w_last) w_state_nxt = ST_HOLD;
            ST_HOLD:      if (w_last) w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (w_last) begin
                    w_state_nxt = (w_init_left || r_pend_valid || w_req) ? ST_SETUP : ST_IDLE;
                end
            end
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture/pending control. A request arriving on the last EXEC cycle with
    // nothing queued is captured directly, matching the idle N+1 latency.
    always_comb begin
        w_init_step = 1'b0;
        w_take_pend = 1'b0;
        w_direct    = 1'b0;
        case (r_state)
`ifdef LCD_INIT_EN
            ST_INIT_WAIT: w_init_step = w_last;
`endif
            ST_IDLE:      w_direct = w_req;
            ST_EXEC: begin
                if (w_last) begin
                    if (w_init_left) begin
                        w_init_step = 1'b1;
                    end else if (r_pend_valid) begin
                        w_take_pend = 1'b1;
                    end else begin
                        w_direct = w_req;
                    end
                end
            end
            default: ;
        endcase

        w_load      = w_init_step | w_take_pend | w_direct;
        w_load_data = r_cap_data;
        w_load_rs   = r_cap_rs;
        if (w_init_step) begin
            w_load_data = w_init_byte;
            w_load_rs   = 1'b0;
        end else if (w_take_pend) begin
            w_load_data = r_pend_data;
            w_load_rs   = r_pend_rs;
        end else if (w_direct) begin
            w_load_data = i_lcd_word[7:0];
            w_load_rs   = i_lcd_word[IDX_RS];
        end

        w_queue          = w_req & ~w_direct;
        w_fill           = w_queue & (~r_pend_valid | w_take_pend);
        w_drop           = w_queue & ~w_fill;
        w_pend_valid_nxt = w_fill | (r_pend_valid & ~w_take_pend);
    end

    assign o_lcd_data = r_cap_data;
    assign o_lcd_rs   = r_cap_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_en;
    assign o_lcd_on   = r_on;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

endmodule

`default_nettype wire

// File: doc/lcd_driver.md
LCD_DRIVER -- requirements
Module: lcd_driver

Interface
REQ-001 SHALL have parameter T_SETUP, default 4, giving the cycles RS/DATA are stable before EN rises.
REQ-002 SHALL have parameter T_PULSE, default 25, giving the cycles EN is held high.
REQ-003 SHALL have parameter T_HOLD, default 4, giving the cycles RS/DATA are held after EN falls.
REQ-004 SHALL have parameter T_EXEC, default 2500, giving the post-transfer wait for normal commands and data.
REQ-005 SHALL have parameter T_EXEC_LONG, default 82000, giving the post-transfer wait for clear and home commands.
REQ-006 SHALL have parameter T_POWERUP, default 2000000, giving the power-up delay (used only with LCD_INIT_EN).
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port i_reset, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port i_lcd_word, input, 32 bits: the LSU LCD register, mapped as [7:0] byte, [8] RS, [9] request toggle, [31] display ON.
REQ-010 SHALL have port o_lcd_data, output, 8 bits: the HD44780 data bus.
REQ-011 SHALL have ports o_lcd_rs, o_lcd_rw, o_lcd_en and o_lcd_on, outputs, 1 bit each: the panel control pins.
REQ-012 SHALL have port o_busy, output, 1 bit: a transfer is active or pending (software polls this via the button/switch input).
REQ-013 SHALL have port o_overrun, output, 1 bit: sticky flag set when a request is dropped.

Function
REQ-014 SHALL detect a request in any cycle where i_lcd_word[9] differs from its registered previous value.
REQ-015 SHALL have FSM states INIT_WAIT, IDLE, SETUP, PULSE, HOLD and EXEC.
REQ-016 SHALL, on a request in cycle N while IDLE with nothing pending, capture byte and RS and enter SETUP at N+1.
REQ-017 SHALL drive o_lcd_data and o_lcd_rs only from the capture register, stable from SETUP through HOLD.
REQ-018 SHALL hold o_lcd_en=1 only in PULSE, with SETUP, PULSE, HOLD and EXEC lasting exactly T_SETUP, T_PULSE, T_HOLD and the selected EXEC count respectively.
REQ-019 SHALL use T_EXEC_LONG when RS=0, byte[7:2]=0 and byte!=0 (commands 0x01-0x03), and T_EXEC otherwise.
REQ-020 SHALL, at the end of EXEC, load the pending entry and enter SETUP next cycle if one is held, otherwise go to IDLE.
REQ-021 SHALL buffer exactly one pending entry: a request while not IDLE fills it if it is empty.
REQ-022 SHALL, on a request while the pending entry is full, drop the request and set o_overrun until reset.
REQ-023 SHALL, when a request and EXEC completion fall in the same cycle, load the old pending entry and place the new request into pending (no drop).
REQ-024 SHALL drive o_busy = (state!=IDLE) | pending_valid, registered.
REQ-025 SHALL drive o_lcd_on = i_lcd_word[31] with one cycle of latency, and tie o_lcd_rw to 0.
REQ-026 SHALL size the timing counter to $clog2 of the largest parameter +1 and reload it on every state entry, with no wrap.

Reset
REQ-027 SHALL asynchronously clear, while i_reset=0: o_lcd_data=0, o_lcd_rs=0, o_lcd_en=0, o_lcd_on=0, o_busy=0, o_overrun=0, the previous-toggle register, pending_valid and the counter.
REQ-028 SHALL set state to IDLE on reset, or to INIT_WAIT with o_busy=1 at the first clock after release when LCD_INIT_EN is defined.
REQ-029 SHALL abandon any transfer in progress on reset mid-operation, forcing EN low immediately and losing the pending entry.

Configuration
REQ-030 SHALL, with LCD_INIT_EN defined, wait T_POWERUP cycles after reset and then issue 0x38, 0x0C, 0x01, 0x06 (RS=0) through SETUP..EXEC, with user requests queued per REQ-021/022 and served after the sequence.
REQ-031 SHALL, without LCD_INIT_EN, omit INIT_WAIT and the init ROM and leave software responsible for initialisation.

Structure
REQ-032 SHALL place the state enum, the LCD word bit positions (IDX_RS=8, IDX_REQ=9, IDX_ON=31) and the init command constants in shared package lcd_pkg.
REQ-033 SHALL be a single module with no sub-module; timer and FSM are inline.

Verification (overrides: T_SETUP=2, T_PULSE=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20, T_POWERUP=10)
REQ-034 SHALL verify: word 0x0000_0241 (toggle 0->1, RS=0, 0x41) -> data=0x41, rs=0, en high for exactly 3 cycles starting 3 cycles after detection, busy drops 5 cycles after HOLD.
REQ-035 SHALL verify: word 0x0000_0001 with toggle -> EXEC lasts 20 cycles; 0x0000_0141 (RS=1) -> EXEC lasts 5 cycles.
REQ-036 SHALL verify: three toggles spaced 1 cycle apart during one transfer -> second is served next, third is dropped, overrun=1 and stays 1.
REQ-037 SHALL verify: i_reset pulled low during PULSE -> en=0 and busy=0 asynchronously, and no further EN pulse after release.
REQ-038 SHALL verify: LCD_INIT_EN defined -> 10-cycle wait, then EN pulses carrying 0x38, 0x0C, 0x01 (20-cycle EXEC), 0x06, then busy=0.
REQ-039 SHALL verify: word bit 31 set with no toggle -> o_lcd_on=1 one cycle later, no EN activity.
